alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n; all state SHALL be clocked on the rising edge of clk.
REQ-002 Port list (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_data, in, 8, command/operand byte.
- in_valid, in, 1, in_data valid.
- in_ready, out, 1, block accepts in_data.
- out_data, out, 8, result byte.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, consumer accepts out_data.
- out_last, out, 1, marks the final result byte.
- busy, out, 1, command in progress.
- alu_din, out, 8, ALU operand bus.
- alu_sel_a, out, 1, 1 loads ALU A; 0 loads ALU B every cycle.
- alu_op, out, 3, ALU opcode.
- alu_fsel, out, 2, ALU flag select.
- alu_res_lo, in, 8, ALU result [7:0].
- alu_res_hi, in, 6, ALU result [13:8].
- alu_flag, in, 1, ALU flag.
- alu_ovf, in, 1, ALU overflow.
REQ-003 Command byte SHALL be decoded as follows:
- [2:0] op.
- [4:3] fsel.
- [5] chain.
- [7:6] ignored.

Function
REQ-004 A byte transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-005 The FSM SHALL have these states: IDLE, GET_A, GET_B, LOAD_A, LOAD_B, SETTLE, OUT_LO, OUT_HI.
REQ-006 in_ready SHALL be 1 only in IDLE, GET_A and GET_B; it is combinational from state.
REQ-007 IDLE: on command transfer, latch op into alu_op and fsel into alu_fsel.
- chain=0: go to GET_A.
- chain=1: load a_q with the previous result low byte (0x00 if no result since reset), go to GET_B.
REQ-008 GET_A: on transfer, a_q<=in_data, go to GET_B. GET_B: on transfer, b_q<=in_data, go to LOAD_A.
REQ-009 LOAD_A SHALL last exactly one cycle: alu_din=a_q, alu_sel_a=1, then go to LOAD_B.
REQ-010 LOAD_B SHALL last exactly one cycle: alu_din=b_q, alu_sel_a=0, then go to SETTLE.
REQ-011 SETTLE SHALL last exactly one cycle and register the following at its end, then go to OUT_LO:
- res_lo<=alu_res_lo.
- res_hi<={alu_flag, alu_ovf, alu_res_hi}.
REQ-012 In every state other than LOAD_A: alu_sel_a=0 and alu_din=b_q, so the ALU B register holds the current operand.
REQ-013 OUT_LO: out_valid=1, out_data=res_lo, out_last=0; on transfer go to OUT_HI.
REQ-014 OUT_HI: out_valid=1, out_data=res_hi, out_last=1; on transfer go to IDLE and mark a chain result as available.
REQ-015 While out_ready=0, out_data, out_valid and out_last SHALL hold stable with no state change; out_valid=0 in all other states.
REQ-016 Latency: first out_valid SHALL assert exactly 3 cycles after the B-byte transfer edge.
REQ-017 alu_op and alu_fsel SHALL hold stable from command acceptance until the next command transfer.
REQ-018 busy SHALL be 0 in IDLE and 1 in every other state.
REQ-019 in_valid asserted in states where in_ready=0 SHALL be ignored; no byte is lost from an upstream that obeys the handshake.
REQ-020 A command transfer in IDLE SHALL be allowed on the same edge that follows the OUT_HI transfer edge (back-to-back commands, no bubble beyond the IDLE cycle).

Reset
REQ-021 rst_n=0 SHALL immediately, without a clock edge, force:
- state=IDLE.
- a_q, b_q, res_lo, res_hi, alu_din, alu_op, alu_fsel = 0.
- alu_sel_a=0.
- out_valid=0, out_last=0, busy=0.
- chain-available flag cleared.
REQ-022 Reset asserted mid-command SHALL abandon the command; after release the block SHALL accept a new command byte in IDLE with in_ready=1.

Verification (bench drives a behavioral 14-bit ALU model on the alu_* ports)
REQ-023 ADD: bytes 0x00, 200, 100 -> out 0x2C then 0xC1 (out_last=1); out_valid exactly 3 cycles after the B transfer.
REQ-024 MUL: bytes 0x0F, 0xFF, 0xFF -> out 0x01 then 0xFE; alu_op=3'b111 and alu_fsel=2'b01 stable throughout.
REQ-025 Chain: after REQ-023, bytes 0x20, 0x01 (no A byte) -> LOAD_A drives alu_din=0x2C; out 0x2D then 0x80.
REQ-026 Backpressure: hold out_ready=0 for 5 cycles in OUT_LO -> out_data=0x2C and out_valid=1 stable; no byte dropped or duplicated.
REQ-027 Reset mid-op: assert rst_n=0 in LOAD_B -> outputs at reset values asynchronously; a chain command as the first command after reset uses A=0x00.
REQ-028 Handshake stress: random in_valid/out_ready gaps over 100 commands -> all results match the model, and in_ready=0 whenever busy=1 outside GET_A/GET_B.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Byte-stream handshake plus external ALU control/result bus between the
// sequencer and its neighbours.
interface alu_seq_ctrl_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic [7:0] alu_din;
   logic       alu_sel_a;
   logic [2:0] alu_op;
   logic [1:0] alu_fsel;
   logic [7:0] alu_res_lo;
   logic [5:0] alu_res_hi;
   logic       alu_flag;
   logic       alu_ovf;

   modport slave (
      input  in_data, in_valid, out_ready,
      input  alu_res_lo, alu_res_hi, alu_flag, alu_ovf,
      output in_ready, out_data, out_valid, out_last, busy,
      output alu_din, alu_sel_a, alu_op, alu_fsel
   );

   modport master (
      output in_data, in_valid, out_ready,
      output alu_res_lo, alu_res_hi, alu_flag, alu_ovf,
      input  in_ready, out_data, out_valid, out_last, busy,
      input  alu_din, alu_sel_a, alu_op, alu_fsel
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences command/operand bytes into an external ALU and streams the result
// back as two bytes: low result byte, then {flag, ovf, res[13:8]}.
//
// state  | meaning
// IDLE   | waiting for a command byte
// GET_A  | waiting for operand A byte
// GET_B  | waiting for operand B byte
// LOAD_A | alu_din = A, alu_sel_a = 1 (one cycle)
// LOAD_B | alu_din = B, alu_sel_a = 0 (one cycle)
// SETTLE | ALU result settles, captured at end of cycle
// OUT_LO | presenting result low byte
// OUT_HI | presenting flag/ovf/high bits, last byte of the result
module alu_seq_ctrl (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_A,
      S_GET_B,
      S_LOAD_A,
      S_LOAD_B,
      S_SETTLE,
      S_OUT_LO,
      S_OUT_HI
   } state_t;

   state_t     state_q;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [7:0] res_lo_q;
   logic [7:0] res_hi_q;
   logic [7:0] alu_din_q;
   logic       alu_sel_a_q;
   logic [2:0] alu_op_q;
   logic [1:0] alu_fsel_q;
   logic [7:0] out_data_q;
   logic       out_valid_q;
   logic       out_last_q;
   logic       busy_q;
   logic       chain_avail_q;

   logic       in_ready;
   logic       in_xfer;
   logic       out_xfer;

   assign in_ready = (state_q == S_IDLE) || (state_q == S_GET_A) || (state_q == S_GET_B);
   assign in_xfer  = bus.in_valid & in_ready;
   assign out_xfer = out_valid_q & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         a_q           <= 8'h00;
         b_q           <= 8'h00;
         res_lo_q      <= 8'h00;
         res_hi_q      <= 8'h00;
         alu_din_q     <= 8'h00;
         alu_sel_a_q   <= 1'b0;
         alu_op_q      <= 3'b000;
         alu_fsel_q    <= 2'b00;
         out_data_q    <= 8'h00;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         busy_q        <= 1'b0;
         chain_avail_q <= 1'b0;
      end else begin
         // Outside LOAD_A the ALU B register keeps tracking the current operand.
         alu_din_q   <= b_q;
         alu_sel_a_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_xfer) begin
                  alu_op_q   <= bus.in_data[2:0];
                  alu_fsel_q <= bus.in_data[4:3];
                  busy_q     <= 1'b1;
                  if (bus.in_data[5]) begin
                     a_q     <= chain_avail_q ? res_lo_q : 8'h00;
                     state_q <= S_GET_B;
                  end else begin
                     state_q <= S_GET_A;
                  end
               end
            end
            S_GET_A: begin
               if (in_xfer) begin
                  a_q     <= bus.in_data;
                  state_q <= S_GET_B;
               end
            end
            S_GET_B: begin
               if (in_xfer) begin
                  b_q         <= bus.in_data;
                  alu_din_q   <= a_q;
                  alu_sel_a_q <= 1'b1;
                  state_q     <= S_LOAD_A;
               end
            end
            S_LOAD_A: state_q <= S_LOAD_B;
            S_LOAD_B: state_q <= S_SETTLE;
            S_SETTLE: begin
               res_lo_q    <= bus.alu_res_lo;
               res_hi_q    <= {bus.alu_flag, bus.alu_ovf, bus.alu_res_hi};
               out_data_q  <= bus.alu_res_lo;
               out_valid_q <= 1'b1;
               out_last_q  <= 1'b0;
               state_q     <= S_OUT_LO;
            end
            S_OUT_LO: begin
               if (out_xfer) begin
                  out_data_q <= res_hi_q;
                  out_last_q <= 1'b1;
                  state_q    <= S_OUT_HI;
               end
            end
            S_OUT_HI: begin
               if (out_xfer) begin
                  out_valid_q   <= 1'b0;
                  out_last_q    <= 1'b0;
                  busy_q        <= 1'b0;
                  chain_avail_q <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
   assign bus.alu_din   = alu_din_q;
   assign bus.alu_sel_a = alu_sel_a_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.alu_fsel  = alu_fsel_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural 14-bit ALU on the alu_* bus, command
// scoreboard, directed cases and randomized handshake traffic.
module tb_alu_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_seq_ctrl_if ifc ();

   alu_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Result = {flag, ovf, res[13:0]}; ovf when the true result leaves 0..255.
   function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [1:0] fs,
                                            input logic [7:0] a, input logic [7:0] b);
      int          ia;
      int          ib;
      int          full;
      logic [13:0] r14;
      logic        ovf;
      logic        flag;
      ia = {24'd0, a};
      ib = {24'd0, b};
      case (op)
         3'd0:    full = ia + ib;
         3'd1:    full = ia - ib;
         3'd2:    full = ia & ib;
         3'd3:    full = ia | ib;
         3'd4:    full = ia ^ ib;
         3'd5:    full = ia << b[2:0];
         3'd6:    full = ia;
         default: full = ia * ib;
      endcase
      r14 = full[13:0];
      ovf = (full < 0) || (full > 255);
      case (fs)
         2'd0:    flag = (r14 != 14'd0);
         2'd1:    flag = r14[0];
         2'd2:    flag = r14[13];
         default: flag = (r14[7:0] == 8'd0);
      endcase
      return {flag, ovf, r14};
   endfunction

   // Behavioural ALU: A loads when alu_sel_a=1, otherwise B loads every cycle.
   logic [7:0]  alu_a_r = 8'h00;
   logic [7:0]  alu_b_r = 8'h00;
   logic [15:0] alu_r;
   always @(posedge clk) begin
      if (ifc.alu_sel_a) alu_a_r <= ifc.alu_din;
      else               alu_b_r <= ifc.alu_din;
   end
   assign alu_r          = alu_calc(ifc.alu_op, ifc.alu_fsel, alu_a_r, alu_b_r);
   assign ifc.alu_res_lo = alu_r[7:0];
   assign ifc.alu_res_hi = alu_r[13:8];
   assign ifc.alu_ovf    = alu_r[14];
   assign ifc.alu_flag   = alu_r[15];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0] cmd;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] ea;
      logic [7:0] lo;
      logic [7:0] hi;
   } cmd_t;

   cmd_t       cmds[$];
   bit         have_prev = 1'b0;
   logic [7:0] prev_lo = 8'h00;

   function automatic void add_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
      cmd_t        e;
      logic [15:0] r;
      e.cmd = c;
      e.a   = a;
      e.b   = b;
      e.ea  = c[5] ? (have_prev ? prev_lo : 8'h00) : a;
      r     = alu_calc(c[2:0], c[4:3], e.ea, b);
      e.lo  = r[7:0];
      e.hi  = r[15:8];
      have_prev = 1'b1;
      prev_lo   = e.lo;
      cmds.push_back(e);
   endfunction

   logic [2:0] cur_op = 3'd0;
   logic [1:0] cur_fsel = 2'd0;
   logic [7:0] cur_a = 8'h00;
   logic [7:0] cur_b = 8'h00;
   bit         exp_busy = 1'b0;
   bit         rdy_open = 1'b0;
   bit         mon_en = 1'b0;
   bit         abort = 1'b0;
   bit         prev_sel = 1'b0;
   int         last_b_cyc = 0;
   int         hi_cyc = 0;

   always @(negedge clk) begin
      if (!rst_n || !mon_en) begin
         prev_sel <= 1'b0;
      end else begin
         check_val("alu_op", 16'(ifc.alu_op), 16'(cur_op));
         check_val("alu_fsel", 16'(ifc.alu_fsel), 16'(cur_fsel));
         check_val("busy", 16'(ifc.busy), 16'(exp_busy));
         check_val("in_ready", 16'(ifc.in_ready), 16'(!exp_busy || rdy_open));
         if (!exp_busy) check_val("oval_idle", 16'(ifc.out_valid), 16'd0);
         if (ifc.alu_sel_a) check_val("load_a_din", 16'(ifc.alu_din), 16'(cur_a));
         if (prev_sel) begin
            check_val("load_b_sel", 16'(ifc.alu_sel_a), 16'd0);
            check_val("load_b_din", 16'(ifc.alu_din), 16'(cur_b));
         end
         prev_sel <= ifc.alu_sel_a;
      end
   end

   task automatic send_byte(input logic [7:0] d, input int gap, output bit ok);
      ok = 1'b0;
      repeat (gap) begin
         @(negedge clk);
         ifc.in_valid = 1'b0;
      end
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      for (int k = 0; k < 400; k++) begin
         if (ifc.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check_val("send_tmo", 16'(ifc.in_ready), 16'd1);
         abort = 1'b1;
         return;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic producer(input int first, input int n, input int max_gap, input bit b2b);
      for (int i = first; i < first + n && !abort; i++) begin
         cmd_t e;
         bit   ok;
         e = cmds[i];
         send_byte(e.cmd, b2b ? 0 : $urandom_range(max_gap, 0), ok);
         if (!ok) break;
         if (b2b && i > first) check_val("b2b_cmd", 16'(cyc - hi_cyc), 16'd1);
         cur_op   = e.cmd[2:0];
         cur_fsel = e.cmd[4:3];
         cur_a    = e.ea;
         cur_b    = e.b;
         exp_busy = 1'b1;
         rdy_open = 1'b1;
         if (!e.cmd[5]) begin
            send_byte(e.a, b2b ? 0 : $urandom_range(max_gap, 0), ok);
            if (!ok) break;
         end
         send_byte(e.b, b2b ? 0 : $urandom_range(max_gap, 0), ok);
         if (!ok) break;
         last_b_cyc = cyc;
         rdy_open   = 1'b0;
      end
      @(negedge clk);
      ifc.in_valid = 1'b0;
   endtask

   task automatic consumer(input int first, input int n, input int rdy_pct, input int stall);
      for (int i = first; i < first + n && !abort; i++) begin
         cmd_t e;
         e = cmds[i];
         for (int beat = 0; beat < 2 && !abort; beat++) begin
            logic [7:0] exp_d;
            bit         seen;
            bit         done;
            int         held;
            exp_d = (beat != 0) ? e.hi : e.lo;
            seen  = 1'b0;
            done  = 1'b0;
            held  = 0;
            for (int k = 0; k < 400 && !done; k++) begin
               @(negedge clk);
               if (ifc.out_valid) begin
                  if (!seen && beat == 0) check_val("latency", 16'(cyc - last_b_cyc), 16'd3);
                  seen = 1'b1;
                  check_val((beat != 0) ? "out_hi" : "out_lo", 16'(ifc.out_data), 16'(exp_d));
                  check_val("out_last", 16'(ifc.out_last), 16'(beat));
               end
               if (seen && beat == 0 && held < stall) begin
                  ifc.out_ready = 1'b0;
                  held++;
               end else begin
                  ifc.out_ready = ($urandom_range(99, 0) < rdy_pct);
               end
               if (ifc.out_valid && ifc.out_ready) begin
                  @(posedge clk);
                  #1;
                  done = 1'b1;
                  if (beat != 0) begin
                     hi_cyc   = cyc;
                     exp_busy = 1'b0;
                  end
               end
            end
            if (!done) begin
               check_val("recv_tmo", 16'(ifc.out_valid), 16'd1);
               abort = 1'b1;
            end
         end
      end
   endtask

   task automatic run_phase(input int first, input int n, input int max_gap, input bit b2b,
                            input int rdy_pct, input int stall);
      fork
         producer(first, n, max_gap, b2b);
         consumer(first, n, rdy_pct, stall);
      join
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_busy"}, 16'(ifc.busy), 16'd0);
      check_val({tag, "_in_ready"}, 16'(ifc.in_ready), 16'd1);
      check_val({tag, "_out_valid"}, 16'(ifc.out_valid), 16'd0);
      check_val({tag, "_out_last"}, 16'(ifc.out_last), 16'd0);
      check_val({tag, "_alu_din"}, 16'(ifc.alu_din), 16'd0);
      check_val({tag, "_alu_sel_a"}, 16'(ifc.alu_sel_a), 16'd0);
      check_val({tag, "_alu_op"}, 16'(ifc.alu_op), 16'd0);
      check_val({tag, "_alu_fsel"}, 16'(ifc.alu_fsel), 16'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      ifc.in_valid  = 1'b0;
      ifc.in_data   = 8'h00;
      ifc.out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_values("por");
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // ADD with 5-cycle backpressure, back-to-back chain, then MUL.
      add_cmd(8'h00, 8'd200, 8'd100);
      add_cmd(8'h20, 8'h00, 8'h01);
      add_cmd(8'h0F, 8'hFF, 8'hFF);
      run_phase(0, 3, 0, 1'b1, 100, 5);

      // Reset while in LOAD_B abandons the command.
      base = cmds.size();
      add_cmd(8'h1B, 8'h5A, 8'h3C);
      producer(base, 1, 0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_mid");
      cur_op    = 3'd0;
      cur_fsel  = 2'd0;
      exp_busy  = 1'b0;
      rdy_open  = 1'b0;
      have_prev = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("rst_hold");
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // First command after reset is a chain: A must be 0x00.
      base = cmds.size();
      add_cmd(8'h20, 8'h99, 8'h05);
      run_phase(base, 1, 0, 1'b0, 100, 0);

      base = cmds.size();
      for (int i = 0; i < 100; i++) add_cmd(8'($urandom), 8'($urandom), 8'($urandom));
      run_phase(base, 100, 3, 1'b0, 60, 0);

      ifc.out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_val("tail_oval", 16'(ifc.out_valid), 16'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
